// File: rtl/ddr_arbiter2.sv
// ddr_arbiter2: two-client burst arbiter for the shared DDR stream port.
// Client A is the save-state engine, client B is the object DMA. One client
// owns port X at a time, for a whole write burst or for a whole read burst
// including every returned beat.
module ddr_arbiter2 #(
  parameter bit FIXED_PRIORITY = 1'b1,  // 1: A wins ties; 0: round-robin
  parameter int BEAT_W         = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [31:0]       a_addr,
  input  logic [63:0]       a_wdata,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [BEAT_W-1:0] a_burstcnt,
  input  logic [7:0]        a_byteenable,
  output logic [63:0]       a_rdata,
  output logic              a_busy,
  output logic              a_rdata_ready,

  input  logic [31:0]       b_addr,
  input  logic [63:0]       b_wdata,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [BEAT_W-1:0] b_burstcnt,
  input  logic [7:0]        b_byteenable,
  output logic [63:0]       b_rdata,
  output logic              b_busy,
  output logic              b_rdata_ready,

  output logic [31:0]       x_addr,
  output logic [63:0]       x_wdata,
  output logic              x_read,
  output logic              x_write,
  output logic [BEAT_W-1:0] x_burstcnt,
  output logic [7:0]        x_byteenable,
  input  logic [63:0]       x_rdata,
  input  logic              x_busy,
  input  logic              x_rdata_ready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_CMD  = 2'd2,
    READ_DATA = 2'd3
  } state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;
  localparam logic [BEAT_W-1:0] ONE_BEAT = BEAT_W'(1);

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic [BEAT_W-1:0] beats_left;

  logic              req_a;
  logic              req_b;
  logic              winner;
  logic              win_write;
  logic [BEAT_W-1:0] win_burstcnt;

  logic              granted;
  logic [31:0]       own_addr;
  logic [63:0]       own_wdata;
  logic              own_read;
  logic              own_write;
  logic [BEAT_W-1:0] own_burstcnt;
  logic [7:0]        own_byteenable;
  logic              own_busy;
  logic              own_rdata_ready;

  assign req_a   = a_read | a_write;
  assign req_b   = b_read | b_write;
  assign granted = (state != IDLE);

  // Pick the winner of an arbitration cycle; only meaningful when someone requests.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    winner = OWNER_A;
    if (req_a && req_b) begin
      winner = FIXED_PRIORITY ? OWNER_A : ~last_owner;
    end else if (req_b) begin
      winner = OWNER_B;
    end
  end

  assign win_write    = (winner == OWNER_B) ? b_write    : a_write;
  assign win_burstcnt = (winner == OWNER_B) ? b_burstcnt : a_burstcnt;

  // Select the owning client's request lines.
  always_comb begin
    own_addr       = a_addr;
    own_wdata      = a_wdata;
    own_read       = a_read;
    own_write      = a_write;
    own_burstcnt   = a_burstcnt;
    own_byteenable = a_byteenable;
    if (owner == OWNER_B) begin
      own_addr       = b_addr;
      own_wdata      = b_wdata;
      own_read       = b_read;
      own_write      = b_write;
      own_burstcnt   = b_burstcnt;
      own_byteenable = b_byteenable;
    end
  end

  // Drive port X: owner's lines while granted, zero in IDLE. The request
  // strobe that does not belong to the current phase is held low, so the
  // DDR side never sees a write during a read grant or vice versa.
  always_comb begin
    x_addr       = '0;
    x_wdata      = '0;
    x_burstcnt   = '0;
    x_byteenable = '0;
    x_read       = 1'b0;
    x_write      = 1'b0;
    if (granted) begin
      x_addr       = own_addr;
      x_wdata      = own_wdata;
      x_burstcnt   = own_burstcnt;
      x_byteenable = own_byteenable;
      x_read       = (state == READ_CMD) && own_read;
      x_write      = (state == WRITE)    && own_write;
    end
  end

  // Stall and read-beat routing: only the owner sees the DDR handshake, and
  // read beats are forwarded only while a read burst is being returned.
  assign own_busy        = (state == READ_DATA) ? 1'b1 : x_busy;
  assign own_rdata_ready = (state == READ_DATA) && x_rdata_ready;

  assign a_busy        = (granted && owner == OWNER_A) ? own_busy : 1'b1;
  assign b_busy        = (granted && owner == OWNER_B) ? own_busy : 1'b1;
  assign a_rdata_ready = (owner == OWNER_A) && own_rdata_ready;
  assign b_rdata_ready = (owner == OWNER_B) && own_rdata_ready;

  // Zero-latency read data path shared by both clients.
  assign a_rdata = x_rdata;
  assign b_rdata = x_rdata;

  // Grant FSM: arbitrate in IDLE, then count beats until the burst completes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state      <= IDLE;
      owner      <= OWNER_A;
      last_owner <= OWNER_B;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            owner      <= winner;
            last_owner <= winner;
            state      <= win_write ? WRITE : READ_CMD;
            // A zero-length burst is still one beat.
            beats_left <= (win_burstcnt == '0) ? ONE_BEAT : win_burstcnt;
          end
        end
        WRITE: begin
          if (x_write && !x_busy) begin
            beats_left <= beats_left - ONE_BEAT;
            if (beats_left == ONE_BEAT) state <= IDLE;
          end
        end
        READ_CMD: begin
          // Grant is held until the command is accepted, even if the owner
          // withdraws its read.
          if (x_read && !x_busy) state <= READ_DATA;
        end
        READ_DATA: begin
          if (x_rdata_ready) begin
            beats_left <= beats_left - ONE_BEAT;
            if (beats_left == ONE_BEAT) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_arbiter2.sv
// tb_ddr_arbiter2: drives two arbiters (fixed priority and round-robin) with
// identical stimulus and compares both, every cycle, against a
// transaction-level model; directed scenarios add literal expectations.
module tb_ddr_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;
  logic        a_read, b_read, a_write, b_write;
  logic [7:0]  a_burstcnt, b_burstcnt;
  logic [7:0]  a_byteenable, b_byteenable;
  logic [63:0] x_rdata;
  logic        x_busy, x_rdata_ready;

  logic [63:0] o_a_rdata [2];
  logic [63:0] o_b_rdata [2];
  logic        o_a_busy [2];
  logic        o_b_busy [2];
  logic        o_a_rr [2];
  logic        o_b_rr [2];
  logic [31:0] o_x_addr [2];
  logic [63:0] o_x_wdata [2];
  logic        o_x_read [2];
  logic        o_x_write [2];
  logic [7:0]  o_x_bc [2];
  logic [7:0]  o_x_be [2];

  int passed = 0;
  int total  = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  ddr_arbiter2 #(.FIXED_PRIORITY(1'b1), .BEAT_W(8)) u_fixed (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_read(a_read), .a_write(a_write),
    .a_burstcnt(a_burstcnt), .a_byteenable(a_byteenable),
    .a_rdata(o_a_rdata[0]), .a_busy(o_a_busy[0]), .a_rdata_ready(o_a_rr[0]),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_read(b_read), .b_write(b_write),
    .b_burstcnt(b_burstcnt), .b_byteenable(b_byteenable),
    .b_rdata(o_b_rdata[0]), .b_busy(o_b_busy[0]), .b_rdata_ready(o_b_rr[0]),
    .x_addr(o_x_addr[0]), .x_wdata(o_x_wdata[0]), .x_read(o_x_read[0]),
    .x_write(o_x_write[0]), .x_burstcnt(o_x_bc[0]), .x_byteenable(o_x_be[0]),
    .x_rdata(x_rdata), .x_busy(x_busy), .x_rdata_ready(x_rdata_ready)
  );

  ddr_arbiter2 #(.FIXED_PRIORITY(1'b0), .BEAT_W(8)) u_rr (
    .clk(clk), .reset(reset),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_read(a_read), .a_write(a_write),
    .a_burstcnt(a_burstcnt), .a_byteenable(a_byteenable),
    .a_rdata(o_a_rdata[1]), .a_busy(o_a_busy[1]), .a_rdata_ready(o_a_rr[1]),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_read(b_read), .b_write(b_write),
    .b_burstcnt(b_burstcnt), .b_byteenable(b_byteenable),
    .b_rdata(o_b_rdata[1]), .b_busy(o_b_busy[1]), .b_rdata_ready(o_b_rr[1]),
    .x_addr(o_x_addr[1]), .x_wdata(o_x_wdata[1]), .x_read(o_x_read[1]),
    .x_write(o_x_write[1]), .x_burstcnt(o_x_bc[1]), .x_byteenable(o_x_be[1]),
    .x_rdata(x_rdata), .x_busy(x_busy), .x_rdata_ready(x_rdata_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  // One record per DUT: the burst currently holding the port, if any.
  typedef struct {
    bit active;     // a client holds the port
    bit owner;      // 0 = A, 1 = B
    bit last;       // most recent grant
    bit is_write;
    bit cmd_done;   // read command already accepted by DDR
    int left;       // beats still to move
  } txn_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        read;
    logic        write;
    logic [7:0]  bc;
    logic [7:0]  be;
    logic        a_busy;
    logic        b_busy;
    logic        a_rr;
    logic        b_rr;
  } exp_t;

  txn_t m [2];

  function automatic exp_t expect_out(input int d);
    exp_t e;
    bit   o;
    bit   returning;
    bit   ob;
    e = '0;
    e.a_busy = 1'b1;
    e.b_busy = 1'b1;
    if (m[d].active) begin
      o = m[d].owner;
      returning = !m[d].is_write && m[d].cmd_done;
      e.addr  = o ? b_addr : a_addr;
      e.wdata = o ? b_wdata : a_wdata;
      e.bc    = o ? b_burstcnt : a_burstcnt;
      e.be    = o ? b_byteenable : a_byteenable;
      if (m[d].is_write) e.write = o ? b_write : a_write;
      else if (!m[d].cmd_done) e.read = o ? b_read : a_read;
      ob = returning ? 1'b1 : x_busy;
      if (o) e.b_busy = ob; else e.a_busy = ob;
      if (returning) begin
        if (o) e.b_rr = x_rdata_ready; else e.a_rr = x_rdata_ready;
      end
    end
    return e;
  endfunction

  // Advance the model on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      bit   ra, rb, w;
      e  = expect_out(d);
      ra = a_read | a_write;
      rb = b_read | b_write;
      if (reset) begin
        m[d] = '{active: 1'b0, owner: 1'b0, last: 1'b1, is_write: 1'b0, cmd_done: 1'b0, left: 0};
      end else if (!m[d].active) begin
        if (ra || rb) begin
          if (ra && rb) w = (d == 0) ? 1'b0 : !m[d].last;
          else w = rb;
          m[d].active   = 1'b1;
          m[d].owner    = w;
          m[d].last     = w;
          m[d].is_write = w ? b_write : a_write;
          m[d].cmd_done = 1'b0;
          m[d].left     = w ? int'(b_burstcnt) : int'(a_burstcnt);
          if (m[d].left == 0) m[d].left = 1;
        end
      end else if (m[d].is_write) begin
        if (e.write && !x_busy) begin
          m[d].left--;
          if (m[d].left == 0) m[d].active = 1'b0;
        end
      end else if (!m[d].cmd_done) begin
        if (e.read && !x_busy) m[d].cmd_done = 1'b1;
      end else if (x_rdata_ready) begin
        m[d].left--;
        if (m[d].left == 0) m[d].active = 1'b0;
      end
    end
  end

  // Compare both DUTs against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (model_on) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        e = expect_out(d);
        check($sformatf("d%0d x_addr", d),   64'(o_x_addr[d]),  64'(e.addr));
        check($sformatf("d%0d x_wdata", d),  o_x_wdata[d],      e.wdata);
        check($sformatf("d%0d x_read", d),   64'(o_x_read[d]),  64'(e.read));
        check($sformatf("d%0d x_write", d),  64'(o_x_write[d]), 64'(e.write));
        check($sformatf("d%0d x_bc", d),     64'(o_x_bc[d]),    64'(e.bc));
        check($sformatf("d%0d x_be", d),     64'(o_x_be[d]),    64'(e.be));
        check($sformatf("d%0d a_busy", d),   64'(o_a_busy[d]),  64'(e.a_busy));
        check($sformatf("d%0d b_busy", d),   64'(o_b_busy[d]),  64'(e.b_busy));
        check($sformatf("d%0d a_rr", d),     64'(o_a_rr[d]),    64'(e.a_rr));
        check($sformatf("d%0d b_rr", d),     64'(o_b_rr[d]),    64'(e.b_rr));
        check($sformatf("d%0d a_rdata", d),  o_a_rdata[d],      x_rdata);
        check($sformatf("d%0d b_rdata", d),  o_b_rdata[d],      x_rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_burstcnt = 0; b_burstcnt = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    a_byteenable = 8'hFF; b_byteenable = 8'hFF;
    x_busy = 0; x_rdata_ready = 0; x_rdata = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    model_on = 1'b1;
    next_cycle();

    // Reset state
    sample();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst d%0d a_busy", d),  64'(o_a_busy[d]),  64'd1);
      check($sformatf("rst d%0d b_busy", d),  64'(o_b_busy[d]),  64'd1);
      check($sformatf("rst d%0d x_write", d), 64'(o_x_write[d]), 64'd0);
      check($sformatf("rst d%0d x_read", d),  64'(o_x_read[d]),  64'd0);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // A writes 4 beats, B idle
    a_write = 1; a_burstcnt = 8'd4; a_addr = 32'h100; a_wdata = 64'hA0;
    sample();
    check("wr arb x_write", 64'(o_x_write[0]), 64'd0);
    check("wr arb a_busy",  64'(o_a_busy[0]),  64'd1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      a_wdata = 64'hA0 + 64'(i);
      sample();
      check($sformatf("wr beat%0d x_write", i), 64'(o_x_write[0]), 64'd1);
      check($sformatf("wr beat%0d x_wdata", i), o_x_wdata[0], 64'hA0 + 64'(i));
      check($sformatf("wr beat%0d b_busy", i),  64'(o_b_busy[0]), 64'd1);
      next_cycle();
    end
    a_write = 0;
    sample();
    check("wr done a_busy", 64'(o_a_busy[0]), 64'd1);
    check("wr done x_write", 64'(o_x_write[0]), 64'd0);
    next_cycle();

    // B reads 2 beats at 0x1000 with 3 stall cycles on the command
    b_read = 1; b_burstcnt = 8'd2; b_addr = 32'h1000; x_busy = 1;
    sample();
    check("rd arb x_read", 64'(o_x_read[0]), 64'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      x_busy = (i < 3);
      sample();
      check($sformatf("rd cmd%0d x_read", i), 64'(o_x_read[0]), 64'd1);
      check($sformatf("rd cmd%0d x_addr", i), 64'(o_x_addr[0]), 64'h1000);
      check($sformatf("rd cmd%0d b_busy", i), 64'(o_b_busy[0]), (i < 3) ? 64'd1 : 64'd0);
      next_cycle();
    end
    b_read = 0; x_busy = 0;
    for (int j = 0; j < 3; j++) begin
      x_rdata_ready = (j != 1);
      x_rdata = (j == 0) ? 64'h1111_1111_1111_1111 : 64'h2222_2222_2222_2222;
      sample();
      check($sformatf("rd beat%0d b_rr", j), 64'(o_b_rr[0]), (j != 1) ? 64'd1 : 64'd0);
      check($sformatf("rd beat%0d a_rr", j), 64'(o_a_rr[0]), 64'd0);
      check($sformatf("rd beat%0d b_rdata", j), o_b_rdata[0], x_rdata);
      check($sformatf("rd beat%0d x_read", j), 64'(o_x_read[0]), 64'd0);
      next_cycle();
    end
    x_rdata_ready = 1;  // stale beat in IDLE must not be forwarded
    sample();
    check("rd idle b_rr", 64'(o_b_rr[0]), 64'd0);
    next_cycle();
    x_rdata_ready = 0;

    // Zero-length write moves exactly one beat
    a_write = 1; a_burstcnt = 8'd0; a_wdata = 64'h5A5A;
    next_cycle();
    sample();
    check("bc0 beat x_write", 64'(o_x_write[0]), 64'd1);
    next_cycle();
    a_write = 0;
    sample();
    check("bc0 done x_write", 64'(o_x_write[0]), 64'd0);
    check("bc0 done a_busy",  64'(o_a_busy[0]),  64'd1);
    next_cycle();

    // Ties: fixed priority always grants A, round-robin alternates from A after reset
    reset = 1;
    next_cycle();
    reset = 0;
    a_write = 1; b_write = 1; a_burstcnt = 8'd1; b_burstcnt = 8'd1;
    a_wdata = 64'hAAAA; b_wdata = 64'hBBBB;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      sample();
      check($sformatf("tie%0d fixed wdata", k), o_x_wdata[0], 64'hAAAA);
      check($sformatf("tie%0d rr wdata", k), o_x_wdata[1], (k % 2 == 1) ? 64'hBBBB : 64'hAAAA);
      next_cycle();
    end
    a_write = 0; b_write = 0;
    next_cycle();

    // Reset during READ_DATA with 3 beats outstanding
    a_read = 1; a_burstcnt = 8'd3;
    next_cycle();
    sample();
    check("rst-rd cmd x_read", 64'(o_x_read[0]), 64'd1);
    next_cycle();
    a_read = 0; reset = 1;
    next_cycle();
    reset = 0;
    for (int j = 0; j < 3; j++) begin
      x_rdata_ready = 1; x_rdata = 64'hDEAD + 64'(j);
      sample();
      check($sformatf("rst-rd beat%0d a_rr", j), 64'(o_a_rr[0]), 64'd0);
      check($sformatf("rst-rd beat%0d b_rr", j), 64'(o_b_rr[0]), 64'd0);
      next_cycle();
    end
    x_rdata_ready = 0;
    b_write = 1; b_burstcnt = 8'd1; b_wdata = 64'hB0B0;
    next_cycle();
    sample();
    check("post-rst b_busy",  64'(o_b_busy[0]),  64'd0);
    check("post-rst x_write", 64'(o_x_write[0]), 64'd1);
    next_cycle();
    b_write = 0;
    next_cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int sa, sb;
      reset = ($urandom_range(0, 99) == 0);
      sa = $urandom_range(0, 9);
      sb = $urandom_range(0, 9);
      a_read  = (sa >= 4 && sa < 7);
      a_write = (sa >= 7);
      b_read  = (sb >= 4 && sb < 7);
      b_write = (sb >= 7);
      a_burstcnt = 8'($urandom_range(0, 4));
      b_burstcnt = 8'($urandom_range(0, 4));
      a_addr = $urandom; b_addr = $urandom;
      a_wdata = {$urandom, $urandom}; b_wdata = {$urandom, $urandom};
      a_byteenable = 8'($urandom); b_byteenable = 8'($urandom);
      x_busy = ($urandom_range(0, 2) == 0);
      x_rdata_ready = 1'($urandom_range(0, 1));
      x_rdata = {$urandom, $urandom};
      next_cycle();
    end

    sample();
    model_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
